muldiv_sequencer: RTL and testbench

//  Multi-cycle sequencer for the EX-stage MULT/MULTU/DIV/DIVU operations, whose destination is HI/LO.

---
 rtl/muldiv_pkg.sv | 27 ++
 rtl/div_radix2_core.sv | 47 ++++
 rtl/muldiv_sequencer.sv | 138 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared state encoding, divider sizing and op decode helpers for the HI/LO sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} muldiv_state_t;

  localparam int DIV_ITER = 32;
  localparam int CNT_W    = $clog2(DIV_ITER + 1);

  // Encodings mirror the shared aluop definitions used by the decoder.
  localparam logic [5:0] ALU_MULT  = 6'h18;
  localparam logic [5:0] ALU_MULTU = 6'h19;
  localparam logic [5:0] ALU_DIV   = 6'h1A;
  localparam logic [5:0] ALU_DIVU  = 6'h1B;

  function automatic logic is_muldiv(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU) || (op == ALU_DIV) || (op == ALU_DIVU);
  endfunction

  function automatic logic is_mul(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_MULTU);
  endfunction

  function automatic logic is_signed_op(input logic [5:0] op);
    return (op == ALU_MULT) || (op == ALU_DIV);
  endfunction

endpackage

// File: rtl/div_radix2_core.sv
// Restoring radix-2 divider on unsigned magnitudes; one quotient bit per step.
module div_radix2_core (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        step,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [32:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [33:0] part;
  logic        ge;

  // Partial remainder shifted left with the next dividend bit brought in.
  assign part = {rem_q, quo_q[31]};
  assign ge   = (part >= {2'b00, dvs_q});

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy  <= 1'b0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
    end else if (clear) begin
      busy <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      rem_q <= '0;
      quo_q <= dividend;
      dvs_q <= divisor;
    end else if (step) begin
      rem_q <= 33'(part - (ge ? {2'b00, dvs_q} : 34'd0));
      quo_q <= {quo_q[30:0], ge};
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q[31:0];

endmodule

// File: rtl/muldiv_sequencer.sv
// EX-stage sequencer for MULT/MULTU/DIV/DIVU; stalls the pipe until {HI,LO} is ready.
// state | meaning
// IDLE  | waiting for a live mul/div op; the accept cycle already stalls
// MUL   | product travelling down the multiplier pipeline
// DIV   | one restoring divide step per cycle
// FIX   | sign correction, result registered into hi_o/lo_o
// DONE  | done_o asserted; held while hold_i
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid_i,
  input  logic [5:0]  ALUop_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  muldiv_state_t      state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               b_zero_q;
  logic               op_signed;
  logic               accept;
  logic               busy_state;
  logic signed [32:0] a_ext;
  logic signed [32:0] b_ext;
  logic [63:0]        mul_pipe_q [MUL_LAT];
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        quo;
  logic [31:0]        rem;
  logic               div_busy;
  logic               div_start;
  logic               div_step;
  logic               div_clear;

  assign op_signed  = is_signed_op(ALUop_i);
  assign accept     = (state_q == IDLE) && valid_i && !flush_i && is_muldiv(ALUop_i);
  assign busy_state = (state_q == MUL) || (state_q == DIV) || (state_q == FIX);
  assign stall_o    = accept || (busy_state && !flush_i);
  assign done_o     = (state_q == DONE) && !flush_i;

  assign a_ext = {op_signed & src_a_i[31], src_a_i};
  assign b_ext = {op_signed & src_b_i[31], src_b_i};
  assign a_mag = (op_signed && src_a_i[31]) ? -src_a_i : src_a_i;
  assign b_mag = (op_signed && src_b_i[31]) ? -src_b_i : src_b_i;

  // Free-running stages; only the sample launched in the accept cycle is consumed.
  always_ff @(posedge clk) begin
    mul_pipe_q[0] <= 64'(a_ext) * 64'(b_ext);
    for (int i = 1; i < MUL_LAT; i++) begin
      mul_pipe_q[i] <= mul_pipe_q[i-1];
    end
  end

  assign div_start = accept && !is_mul(ALUop_i);
  assign div_step  = (state_q == DIV) && div_busy;
  assign div_clear = flush_i || (state_q == FIX);

  div_radix2_core u_div (
    .clk       (clk),
    .resetn    (resetn),
    .start     (div_start),
    .step      (div_step),
    .clear     (div_clear),
    .dividend  (a_mag),
    .divisor   (b_mag),
    .busy      (div_busy),
    .quotient  (quo),
    .remainder (rem)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      b_zero_q <= 1'b0;
      hi_o     <= '0;
      lo_o     <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q  <= is_mul(ALUop_i) ? MUL : DIV;
            cnt_q    <= '0;
            q_neg_q  <= op_signed && (src_a_i[31] ^ src_b_i[31]);
            r_neg_q  <= op_signed && src_a_i[31];
            b_zero_q <= (src_b_i == 32'd0);
          end
        end
        MUL: begin
          if (cnt_q == CNT_W'(MUL_LAT - 1)) begin
            state_q <= DONE;
            cnt_q   <= '0;
            hi_o    <= mul_pipe_q[MUL_LAT-1][63:32];
            lo_o    <= mul_pipe_q[MUL_LAT-1][31:0];
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DIV: begin
          if (cnt_q == CNT_W'(DIV_ITER - 1)) begin
            state_q <= FIX;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIX: begin
          // Divide by zero leaves the dividend as remainder and an all-ones quotient.
          hi_o    <= r_neg_q ? -rem : rem;
          lo_o    <= b_zero_q ? 32'hFFFF_FFFF : (q_neg_q ? -quo : quo);
          state_q <= DONE;
        end
        DONE: begin
          if (!hold_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expectations, a monitor checks them.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  typedef struct {
    bit          probe;
    logic [31:0] hi;
    logic [31:0] lo;
    int          stalls;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        valid_i = 1'b0;
  logic        hold_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [5:0]  ALUop_i = 6'd0;
  logic [31:0] src_a_i = 32'd0;
  logic [31:0] src_b_i = 32'd0;
  logic        stall_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   tb_end = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.MUL_LAT(2)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .valid_i (valid_i),
    .ALUop_i (ALUop_i),
    .src_a_i (src_a_i),
    .src_b_i (src_b_i),
    .hold_i  (hold_i),
    .flush_i (flush_i),
    .stall_o (stall_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  task automatic push_probe(input logic [31:0] eh, input logic [31:0] el, input int st);
    exp_t e;
    e.probe = 1'b1; e.hi = eh; e.lo = el; e.stalls = st;
    exp_q.push_back(e);
  endtask

  // Issue one op, hold EX for the expected stall, keep hold_i for `holds` DONE cycles.
  task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int st, input int holds);
    exp_t e;
    @(negedge clk);
    valid_i = 1'b1; ALUop_i = op; src_a_i = a; src_b_i = b; hold_i = (holds > 0);
    e.probe = 1'b0; e.hi = eh; e.lo = el; e.stalls = st;
    exp_q.push_back(e);
    repeat (st + holds) @(negedge clk);
    hold_i = 1'b0; valid_i = 1'b0; ALUop_i = 6'd0;
  endtask

  initial begin
    push_probe(32'h0, 32'h0, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    run_op(ALU_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 0);
    run_op(ALU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 0);
    run_op(ALU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3, 0);
    run_op(ALU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0);
    run_op(ALU_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003, 34, 0);
    run_op(ALU_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 34, 0);
    run_op(ALU_DIVU,  32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 34, 0);
    run_op(ALU_DIV,   32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, 0);
    run_op(ALU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 34, 0);
    run_op(ALU_DIVU,  32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 34, 0);

    // A live non-muldiv op must be ignored.
    @(negedge clk);
    valid_i = 1'b1; ALUop_i = 6'h20; src_a_i = 32'd9; src_b_i = 32'd4;
    @(negedge clk);
    push_probe(32'h0000_0005, 32'h1999_9999, 0);
    @(negedge clk);
    valid_i = 1'b0; ALUop_i = 6'd0;

    // Flush during divide iteration 10.
    @(negedge clk);
    valid_i = 1'b1; ALUop_i = ALU_DIV; src_a_i = 32'd64; src_b_i = 32'd3;
    repeat (11) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ALUop_i = 6'd0;
    push_probe(32'h0000_0005, 32'h1999_9999, 11);
    run_op(ALU_DIV, 32'hFFFF_FF9C, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 34, 0);

    // Flush beats a simultaneous accept.
    @(negedge clk);
    valid_i = 1'b1; ALUop_i = ALU_MULT; src_a_i = 32'd3; src_b_i = 32'd3; flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0; ALUop_i = 6'd0;
    push_probe(32'hFFFF_FFFE, 32'hFFFF_FFF2, 0);

    // DONE held for three cycles, then a back-to-back MULT.
    run_op(ALU_MULT, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 3, 3);
    run_op(ALU_MULT, 32'h0001_2345, 32'h0000_0100, 32'h0000_0000, 32'h0123_4500, 3, 0);

    // Reset pulled in the middle of a divide.
    @(negedge clk);
    valid_i = 1'b1; ALUop_i = ALU_DIVU; src_a_i = 32'd100; src_b_i = 32'd3;
    repeat (5) @(negedge clk);
    resetn = 1'b0; valid_i = 1'b0; ALUop_i = 6'd0;
    push_probe(32'h0, 32'h0, 5);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    run_op(ALU_MULTU, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000, 3, 0);

    repeat (3) @(negedge clk);
    tb_end = 1'b1;
  end

  initial begin : monitor
    exp_t e;
    int   stall_cnt;
    int   cyc;
    stall_cnt = 0;
    cyc = 0;
    forever begin
      @(negedge clk);
      #3;
      cyc++;
      if (stall_o) stall_cnt++;
      if (done_o) begin
        if (exp_q.size() == 0 || exp_q[0].probe) begin
          total++; bad++;
          $display("FAIL unexpected_done t=%0t hi=%h lo=%h", $time, hi_o, lo_o);
        end else begin
          e = exp_q[0];
          total++;
          if (hi_o !== e.hi || lo_o !== e.lo) begin
            bad++;
            $display("FAIL result t=%0t got hi=%h lo=%h want hi=%h lo=%h", $time, hi_o, lo_o, e.hi, e.lo);
          end
          total++;
          if (stall_o !== 1'b0) begin
            bad++;
            $display("FAIL done_stall t=%0t got stall=%b want 0", $time, stall_o);
          end
          if (!hold_i) begin
            total++;
            if (stall_cnt != e.stalls) begin
              bad++;
              $display("FAIL stall_count t=%0t got %0d want %0d", $time, stall_cnt, e.stalls);
            end
            stall_cnt = 0;
            void'(exp_q.pop_front());
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].probe) begin
        e = exp_q[0];
        total++;
        if (hi_o !== e.hi || lo_o !== e.lo) begin
          bad++;
          $display("FAIL probe_hilo t=%0t got hi=%h lo=%h want hi=%h lo=%h", $time, hi_o, lo_o, e.hi, e.lo);
        end
        total++;
        if (stall_cnt != e.stalls) begin
          bad++;
          $display("FAIL probe_stalls t=%0t got %0d want %0d", $time, stall_cnt, e.stalls);
        end
        total++;
        if (stall_o !== 1'b0) begin
          bad++;
          $display("FAIL probe_stall t=%0t got stall=%b want 0", $time, stall_o);
        end
        stall_cnt = 0;
        void'(exp_q.pop_front());
      end
      if (tb_end || cyc > 5000) begin
        total++;
        if (!tb_end || exp_q.size() != 0) begin
          bad++;
          $display("FAIL pending t=%0t got %0d outstanding (ended=%b) want 0", $time, exp_q.size(), tb_end);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

endmodule
